// File: rtl/vga_pkg.sv
// Shared VGA timing definitions.
//  - vga_timing_t : one complete horizontal/vertical timing set with sync polarity
//  - VGA_640X480 / VGA_800X600 / VGA_1024X768 : standard 60 Hz modes
//  - POL_NEG / POL_POS : sync polarity encodings
//  - vga_sync_t : sync/blank bundle carried through the pixel-latency pipeline
//  - chan_msbs() : top N bits of an 8-bit colour channel, right-aligned
package vga_pkg;

   localparam bit POL_NEG = 1'b0;
   localparam bit POL_POS = 1'b1;

   typedef struct packed {
      int unsigned h_active;
      int unsigned h_fp;
      int unsigned h_sync;
      int unsigned h_bp;
      int unsigned v_active;
      int unsigned v_fp;
      int unsigned v_sync;
      int unsigned v_bp;
      bit          hs_pol;
      bit          vs_pol;
   } vga_timing_t;

   localparam vga_timing_t VGA_640X480 = '{
      h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
      hs_pol: POL_NEG, vs_pol: POL_NEG};

   localparam vga_timing_t VGA_800X600 = '{
      h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
      v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
      hs_pol: POL_POS, vs_pol: POL_POS};

   localparam vga_timing_t VGA_1024X768 = '{
      h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
      v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29,
      hs_pol: POL_NEG, vs_pol: POL_NEG};

   // Raw (polarity-free) timing flags for one counter position.
   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } vga_sync_t;

   // Keeps the n most significant bits of a channel, right-aligned.
   function automatic logic [7:0] chan_msbs(input logic [7:0] chan, input int n);
      return chan >> (8 - n);
   endfunction

endpackage

// File: rtl/vga_hv_counter.sv
// Horizontal/vertical position counter with raw timing decode.
//  clk, rst : pixel clock, synchronous active-high reset
//  en       : pixel tick; low holds the position
//  col/line : current fetch position (registers)
//  active   : position lies inside the visible area
//  hs_raw   : position lies inside the horizontal sync window
//  vs_raw   : line lies inside the vertical sync window
module vga_hv_counter #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int CW      = $clog2(H_TOTAL),
   localparam int LW      = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic [CW-1:0] col,
   output logic [LW-1:0] line,
   output logic          active,
   output logic          hs_raw,
   output logic          vs_raw
);

   localparam logic [CW-1:0] COL_LAST  = CW'(H_TOTAL - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(V_TOTAL - 1);
   localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [LW-1:0] VS_START  = LW'(V_ACTIVE + V_FP);
   localparam logic [LW-1:0] VS_END    = LW'(V_ACTIVE + V_FP + V_SYNC);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         col  <= '0;
         line <= '0;
      end else if (en) begin
         if (col == COL_LAST) begin
            col  <= '0;
            line <= (line == LINE_LAST) ? '0 : line + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // vs_raw only depends on line, so it changes at the column wrap.
   assign active = (col < CW'(H_ACTIVE)) && (line < LW'(V_ACTIVE));
   assign hs_raw = (col >= HS_START) && (col < HS_END);
   assign vs_raw = (line >= VS_START) && (line < VS_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/colour generator.
//  clk, rst      : pixel clock, synchronous active-high reset (overrides en)
//  en            : pixel tick; low freezes all state and forces strobes low
//  pixel         : fetched pixel {ignored, R, G, B}, valid PIX_LATENCY ticks after COL/LINE
//  COL, LINE     : fetch coordinate to the frame buffer
//  fetch_valid   : COL/LINE inside the active area
//  frame_start   : pulse at fetch (0,0)
//  line_start    : pulse at COL==0 on an active line
//  R, G, B       : registered colour, channel MSBs, zero while blanked
//  HS, VS        : registered syncs with configured polarity
//  inDisplayArea : registered DE aligned with R/G/B
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int DEEP_COLOR  = 1,
   parameter int H_ACTIVE    = VGA_640X480.h_active,
   parameter int H_FP        = VGA_640X480.h_fp,
   parameter int H_SYNC      = VGA_640X480.h_sync,
   parameter int H_BP        = VGA_640X480.h_bp,
   parameter int V_ACTIVE    = VGA_640X480.v_active,
   parameter int V_FP        = VGA_640X480.v_fp,
   parameter int V_SYNC      = VGA_640X480.v_sync,
   parameter int V_BP        = VGA_640X480.v_bp,
   parameter bit HS_POL      = VGA_640X480.hs_pol,
   parameter bit VS_POL      = VGA_640X480.vs_pol,
   parameter int PIX_LATENCY = 1,
   localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int CW         = $clog2(H_TOTAL),
   localparam int LW         = $clog2(V_TOTAL)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [31:0]           pixel,
   output logic [CW-1:0]         COL,
   output logic [LW-1:0]         LINE,
   output logic                  fetch_valid,
   output logic                  frame_start,
   output logic                  line_start,
   output logic [DEEP_COLOR-1:0] R,
   output logic [DEEP_COLOR-1:0] G,
   output logic [DEEP_COLOR-1:0] B,
   output logic                  HS,
   output logic                  VS,
   output logic                  inDisplayArea
);

   if (DEEP_COLOR < 1 || DEEP_COLOR > 8) begin : g_bad_deep_color
      $fatal(1, "DEEP_COLOR must be 1..8");
   end
   if (PIX_LATENCY < 1 || PIX_LATENCY > 8) begin : g_bad_latency
      $fatal(1, "PIX_LATENCY must be 1..8");
   end
   if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
   begin : g_bad_timing
      $fatal(1, "every porch and sync width must be at least 1");
   end

   logic hs_raw, vs_raw;

   vga_hv_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_counter (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .col    (COL),
      .line   (LINE),
      .active (fetch_valid),
      .hs_raw (hs_raw),
      .vs_raw (vs_raw)
   );

   assign frame_start = fetch_valid && (COL == '0) && (LINE == '0) && en;
   assign line_start  = fetch_valid && (COL == '0) && en;

   // Delays the timing flags so they meet the pixel fetched for the same position.
   vga_sync_t sync_pipe [PIX_LATENCY];
   vga_sync_t sync_dly;

   // NOTE: the pipeline is reset on purpose; a restart must not replay stale
   // sync or DE from the interrupted frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PIX_LATENCY; i++) sync_pipe[i] <= '0;
      end else if (en) begin
         sync_pipe[0] <= '{hs: hs_raw, vs: vs_raw, de: fetch_valid};
         for (int i = 1; i < PIX_LATENCY; i++) sync_pipe[i] <= sync_pipe[i-1];
      end
   end

   assign sync_dly = sync_pipe[PIX_LATENCY-1];

   logic [DEEP_COLOR-1:0] r_msb, g_msb, b_msb;
   logic                  unused_pixel_bits;

   assign r_msb = DEEP_COLOR'(chan_msbs(pixel[23:16], DEEP_COLOR));
   assign g_msb = DEEP_COLOR'(chan_msbs(pixel[15:8],  DEEP_COLOR));
   assign b_msb = DEEP_COLOR'(chan_msbs(pixel[7:0],   DEEP_COLOR));
   assign unused_pixel_bits = ^pixel[31:24];

   always_ff @(posedge clk) begin
      if (rst) begin
         R             <= '0;
         G             <= '0;
         B             <= '0;
         HS            <= ~HS_POL;
         VS            <= ~VS_POL;
         inDisplayArea <= 1'b0;
      end else if (en) begin
         // Blanked positions never let the pixel bus reach the pins.
         R             <= sync_dly.de ? r_msb : '0;
         G             <= sync_dly.de ? g_msb : '0;
         B             <= sync_dly.de ? b_msb : '0;
         HS            <= sync_dly.hs ? HS_POL : ~HS_POL;
         VS            <= sync_dly.vs ? VS_POL : ~VS_POL;
         inDisplayArea <= sync_dly.de;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

   localparam int DC  = 4;
   localparam int HA  = 16, HF = 2, HSY = 3, HB = 4;
   localparam int VA  = 6,  VF = 1, VSY = 2, VB = 1;
   localparam int LAT = 3;
   localparam bit HP  = 1'b0;
   localparam bit VP  = 1'b1;
   localparam int HT  = HA + HF + HSY + HB;
   localparam int VT  = VA + VF + VSY + VB;
   localparam int CW  = $clog2(HT);
   localparam int LW  = $clog2(VT);

   logic          clk = 1'b0;
   logic          rst, en;
   logic [31:0]   pixel;
   logic [CW-1:0] COL;
   logic [LW-1:0] LINE;
   logic          fetch_valid, frame_start, line_start;
   logic [DC-1:0] R, G, B;
   logic          HS, VS, inDisplayArea;

   vga_timing_gen #(
      .DEEP_COLOR (DC),
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
      .HS_POL (HP), .VS_POL (VP),
      .PIX_LATENCY (LAT)
   ) dut (
      .clk (clk), .rst (rst), .en (en), .pixel (pixel),
      .COL (COL), .LINE (LINE),
      .fetch_valid (fetch_valid), .frame_start (frame_start), .line_start (line_start),
      .R (R), .G (G), .B (B), .HS (HS), .VS (VS),
      .inDisplayArea (inDisplayArea)
   );

   always #5 clk = ~clk;

   // Reference model: position counted with plain arithmetic, timing decoded
   // from the window definitions, and a queue holding the flags of the last
   // LAT enabled positions.
   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } tim_t;

   tim_t          tq[$];
   int            mcol, mline;
   logic [DC-1:0] er, eg, eb;
   logic          ehs, evs, ede;
   int            n_vec = 0;
   int            n_err = 0;
   int            hs_low_cnt, vs_act_cnt;

   function automatic tim_t pos_tim(int c, int l);
      tim_t t;
      t.de = (c < HA) && (l < VA);
      t.hs = (c >= HA + HF) && (c < HA + HF + HSY);
      t.vs = (l >= VA + VF) && (l < VA + VF + VSY);
      return t;
   endfunction

   function automatic logic [DC-1:0] top_bits(logic [7:0] ch);
      logic [7:0] s;
      s = ch >> (8 - DC);
      return s[DC-1:0];
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mcol = 0;
      mline = 0;
      tq.delete();
      repeat (LAT) tq.push_back('0);
      er = '0; eg = '0; eb = '0;
      ehs = !HP; evs = !VP; ede = 1'b0;
   endtask

   // One clock: drive inputs, advance the model on the edge, compare #1 later.
   task automatic step(bit r, bit e, logic [31:0] p);
      tim_t t;
      logic fv;
      rst = r; en = e; pixel = p;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else if (e) begin
         tq.push_back(pos_tim(mcol, mline));
         t   = tq.pop_front();
         ede = t.de;
         ehs = t.hs ? HP : !HP;
         evs = t.vs ? VP : !VP;
         er  = t.de ? top_bits(p[23:16]) : '0;
         eg  = t.de ? top_bits(p[15:8])  : '0;
         eb  = t.de ? top_bits(p[7:0])   : '0;
         if (mcol == HT - 1) begin
            mcol  = 0;
            mline = (mline == VT - 1) ? 0 : mline + 1;
         end else begin
            mcol++;
         end
      end
      #1;
      fv = (mcol < HA) && (mline < VA);
      check("COL",         32'(COL),         32'(mcol));
      check("LINE",        32'(LINE),        32'(mline));
      check("fetch_valid", 32'(fetch_valid), 32'(fv));
      check("frame_start", 32'(frame_start), 32'(fv && mcol == 0 && mline == 0 && e));
      check("line_start",  32'(line_start),  32'(fv && mcol == 0 && e));
      check("R",           32'(R),           32'(er));
      check("G",           32'(G),           32'(eg));
      check("B",           32'(B),           32'(eb));
      check("HS",          32'(HS),          32'(ehs));
      check("VS",          32'(VS),          32'(evs));
      check("DE",          32'(inDisplayArea), 32'(ede));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; pixel = '0;
      model_reset();

      // Reset state, with and without en.
      step(1'b1, 1'b0, 32'hFFFF_FFFF);
      step(1'b1, 1'b1, 32'hFFFF_FFFF);
      step(1'b1, 1'b0, 32'h00FF_8001);

      // Two full frames at en=1, random pixels; measure pin pulse widths.
      hs_low_cnt = 0;
      vs_act_cnt = 0;
      for (int i = 0; i < 2 * HT * VT; i++) begin
         step(1'b0, 1'b1, $urandom);
         if (HS == HP) hs_low_cnt++;
         if (VS == VP) vs_act_cnt++;
      end
      check("hs_pulse_total", 32'(hs_low_cnt), 32'(2 * VT * HSY));
      check("vs_pulse_total", 32'(vs_act_cnt), 32'(2 * VSY * HT));

      // Fixed colour pattern: MSBs F/8/0 in the active area.
      for (int i = 0; i < HT * 2; i++) step(1'b0, 1'b1, 32'h00FF_8001);

      // Random clock enable.
      for (int i = 0; i < 600; i++) step(1'b0, 1'($urandom_range(0, 1)), $urandom);

      // Alternating enable: the design advances every other clock.
      for (int i = 0; i < 2 * HT * VT; i++) step(1'b0, 1'(i % 2 == 0), $urandom);

      // Mid-frame reset inside the active area, bounded search for the position.
      begin
         int guard = 0;
         while (!(mline == 4 && mcol == 10) && guard < 2 * HT * VT) begin
            step(1'b0, 1'b1, $urandom);
            guard++;
         end
         check("reset_point_reached", 32'(guard < 2 * HT * VT), 32'd1);
      end
      step(1'b1, 1'b0, $urandom);
      step(1'b0, 1'b0, $urandom);
      for (int i = 0; i < 300; i++) step(1'b0, 1'b1, $urandom);

      // Reset during vertical sync, then recover.
      begin
         int guard = 0;
         while (mline != VA + VF && guard < 2 * HT * VT) begin
            step(1'b0, 1'b1, $urandom);
            guard++;
         end
         check("vsync_point_reached", 32'(guard < 2 * HT * VT), 32'd1);
      end
      step(1'b1, 1'b1, $urandom);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, $urandom);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA sync/colour generator. It provides fully configurable horizontal and vertical timing, sync polarity, colour depth, pixel-fetch latency compensation and a clock enable. The block issues fetch coordinates to the frame-buffer side. It realigns the returned pixel with delayed sync and blanking, then drives registered R/G/B, HS, VS and DE to the DAC/connector pins.

Parameters:
DEEP_COLOR, 1, bits per colour channel on R/G/B outputs (1..8).
H_ACTIVE, 640, visible pixels per line.
H_FP, 16, horizontal front porch (clocks).
H_SYNC, 96, horizontal sync width (clocks).
H_BP, 48, horizontal back porch (clocks).
V_ACTIVE, 480, visible lines per frame.
V_FP, 10, vertical front porch (lines).
V_SYNC, 2, vertical sync width (lines).
V_BP, 33, vertical back porch (lines).
HS_POL, 0, active level of HS (0 = negative).
VS_POL, 0, active level of VS (0 = negative).
PIX_LATENCY, 1, clocks from fetch coordinate to valid pixel input (1..8).

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
en  in  1  clock enable (pixel tick); low freezes all state
pixel  in  32  fetched pixel: [31:24] ignored, [23:16] Red, [15:8] Green, [7:0] Blue
COL  out  CW  fetch column, CW = $clog2(H_TOTAL), H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
LINE  out  LW  fetch line, LW = $clog2(V_TOTAL)
fetch_valid  out  1  COL/LINE lie inside the active area
frame_start  out  1  one-cycle pulse at fetch (0,0)
line_start  out  1  one-cycle pulse at COL==0 on an active line
R, G, B  out  DEEP_COLOR each  colour outputs
HS, VS  out  1  sync outputs
inDisplayArea  out  1  DE, aligned with R/G/B

Behaviour:
- Counter stage. COL and LINE are registers.
  - On each clk with en=1, COL increments.
  - At COL==H_TOTAL-1, COL wraps to 0 and LINE increments.
  - LINE wraps to 0 after V_TOTAL-1.
  - Each line runs in the order active, FP, sync, BP; the frame uses the same order for lines.
- fetch_valid = (COL<H_ACTIVE)&&(LINE<V_ACTIVE), decoded combinationally from the counter registers.
  - frame_start = fetch_valid && COL==0 && LINE==0 && en.
  - line_start = fetch_valid && COL==0 && en.
- Raw timing for the counter position:
  - hs_raw active when H_ACTIVE+H_FP <= COL < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw active when V_ACTIVE+V_FP <= LINE < V_ACTIVE+V_FP+V_SYNC. VS switches with the COL wrap, not mid-line.
- Alignment:
  - hs_raw, vs_raw and fetch_valid pass through a PIX_LATENCY-deep shift register, advancing only when en=1.
  - The shift-register output is combined with `pixel` and registered into the outputs.
  - Total latency from counter position to pins is PIX_LATENCY+1 enabled clocks.
- Colour: R = pixel[23:24-DEEP_COLOR], G = pixel[15:16-DEEP_COLOR], B = pixel[7:8-DEEP_COLOR] (channel MSBs).
  - When delayed DE=0, R/G/B = 0.
  - `pixel` is ignored whenever its delayed DE is 0.
- Polarity: HS = hs_delayed ? HS_POL : ~HS_POL; VS likewise with VS_POL.
- en=0: counters, shift register and output registers all hold; strobes forced 0.
- Reset (overrides en):
  - COL=0, LINE=0.
  - Shift register cleared to inactive.
  - R=G=B=0, inDisplayArea=0, HS=~HS_POL, VS=~VS_POL.
  - The first enabled cycle after reset fetches (0,0) and pulses frame_start.
  - Reset mid-frame restarts the frame immediately; no partial sync pulse is stretched.
- Elaboration-time checks (fatal):
  - DEEP_COLOR in 1..8.
  - PIX_LATENCY in 1..8.
  - Every porch and sync width >=1.

Decomposition:
- Shared package vga_pkg holds:
  - timing constant sets for 640x480@60, 800x600@60 and 1024x768@60;
  - the polarity localparams;
  - a function extracting the top N bits of an 8-bit channel.
- One sub-module, vga_hv_counter, contains COL/LINE, the wrap logic and the raw hs/vs/active decode.
- The top level contains the latency shift register and the output registers.

Test Plan:
1. Defaults, en=1, 2 frames: HS at pins is low for 96 clocks (fetch COL 656..751, seen at pins +2). Line period is 800 clocks, frame period 420000 clocks, VS low for 1600 clocks on LINE 490..491.
2. pixel=32'h00FF8001, DEEP_COLOR=4: active pins show R=4'hF, G=4'h8, B=4'h0; in blanking R=G=B=0 regardless of pixel.
3. PIX_LATENCY=3, pixel = {8'h0, COL[7:0] replicated}: pin R equals the fetched COL's MSBs exactly 4 clocks later; inDisplayArea rises 4 clocks after frame_start.
4. en toggled 1/0 every other clock (50 MHz host): HS low for 192 clk cycles; outputs and counters never change while en=0.
5. rst asserted 1 clock at LINE=300, COL=400: next clock COL=0, LINE=0, HS=VS=1, DE=0; frame_start pulses on the first enabled clock after reset.
6. HS_POL=1, VS_POL=1, 800x600 set from vga_pkg: sync pulses are high and sit at the package-defined positions; H_TOTAL=1056 and V_TOTAL=628 are verified.
